// File: rtl/wave_param_bank.sv
// Double-buffered 32-channel parameter bank: host writes land in a shadow bank,
// and a commit copies the whole shadow bank to the active outputs on a frame tick.
module wave_param_bank #(
  parameter int NCH = 32,
  parameter int W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)-1:0]   wr_chan,
  input  logic [1:0]               wr_field,
  input  logic [W-1:0]             wr_data,
  input  logic                     commit,
  input  logic                     sample_tick,
  output logic [NCH*W-1:0]         amps,
  output logic [NCH*W-1:0]         offsets,
  output logic [NCH*W-1:0]         phasewords,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic                     wr_err
);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  localparam logic [1:0] FIELD_AMP    = 2'd0;
  localparam logic [1:0] FIELD_OFFSET = 2'd1;
  localparam logic [1:0] FIELD_PHASE  = 2'd2;
  localparam logic [1:0] FIELD_RSVD   = 2'd3;

  state_t state;

  logic [W-1:0] sh_amp    [NCH];
  logic [W-1:0] sh_offset [NCH];
  logic [W-1:0] sh_phase  [NCH];

  logic apply;

  // A commit is published on the first tick at or after it; a tick alone does nothing.
  always_comb begin
    apply = 1'b0;
    if (sample_tick) begin
      apply = (state == ARMED) || commit;
    end
  end

  // Shadow bank: one field of one channel per cycle, reserved field is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        sh_amp[i]    <= '0;
        sh_offset[i] <= '0;
        sh_phase[i]  <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (wr_field == FIELD_RSVD);
      if (wr_en) begin
        case (wr_field)
          FIELD_AMP:    sh_amp[wr_chan]    <= wr_data;
          FIELD_OFFSET: sh_offset[wr_chan] <= wr_data;
          FIELD_PHASE:  sh_phase[wr_chan]  <= wr_data;
          default:      ;
        endcase
      end
    end
  end

  // Active bank copies the pre-write shadow contents, so a same-edge write waits for the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      amps       <= '0;
      offsets    <= '0;
      phasewords <= '0;
    end else if (apply) begin
      for (int i = 0; i < NCH; i++) begin
        amps[i*W +: W]       <= sh_amp[i];
        offsets[i*W +: W]    <= sh_offset[i];
        phasewords[i*W +: W] <= sh_phase[i];
      end
    end
  end

  // Commit state machine with registered pending/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      commit_done <= apply;
      case (state)
        IDLE: begin
          if (commit && !sample_tick) begin
            state          <= ARMED;
            commit_pending <= 1'b1;
          end else begin
            commit_pending <= 1'b0;
          end
        end
        ARMED: begin
          if (sample_tick) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
          end else begin
            commit_pending <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          commit_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_param_bank.sv
// Self-checking bench for wave_param_bank: directed test-plan scenarios plus
// randomized traffic compared every cycle against an array-based bank model.
module tb_wave_param_bank;

  localparam int NCH = 32;
  localparam int W   = 16;
  localparam int CW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [CW-1:0]     wr_chan;
  logic [1:0]        wr_field;
  logic [W-1:0]      wr_data;
  logic              commit;
  logic              sample_tick;
  logic [NCH*W-1:0]  amps;
  logic [NCH*W-1:0]  offsets;
  logic [NCH*W-1:0]  phasewords;
  logic              commit_pending;
  logic              commit_done;
  logic              wr_err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_sh  [3][NCH];
  logic [W-1:0] m_act [3][NCH];
  bit           m_pend;
  bit           m_done;
  bit           m_err;

  always #5 clk = ~clk;

  wave_param_bank #(.NCH(NCH), .W(W)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_chan(wr_chan),
    .wr_field(wr_field),
    .wr_data(wr_data),
    .commit(commit),
    .sample_tick(sample_tick),
    .amps(amps),
    .offsets(offsets),
    .phasewords(phasewords),
    .commit_pending(commit_pending),
    .commit_done(commit_done),
    .wr_err(wr_err)
  );

  task automatic checkOutput(input string tag, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] packField(input int f);
    logic [NCH*W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = m_act[f][i];
    return r;
  endfunction

  // One clock edge of the bank's behaviour, using the inputs held across the edge.
  task automatic modelStep();
    bit do_apply;
    if (reset) begin
      for (int f = 0; f < 3; f++)
        for (int i = 0; i < NCH; i++) begin
          m_sh[f][i]  = '0;
          m_act[f][i] = '0;
        end
      m_pend = 0;
      m_done = 0;
      m_err  = 0;
    end else begin
      do_apply = sample_tick && (m_pend || commit);
      if (do_apply) m_act = m_sh;
      m_done = do_apply;
      m_err  = wr_en && (wr_field == 2'd3);
      if (sample_tick) m_pend = 0;
      else if (commit) m_pend = 1;
      if (wr_en && wr_field != 2'd3) m_sh[wr_field][wr_chan] = wr_data;
    end
  endtask

  task automatic checkAll();
    checkOutput("amps", amps, packField(0));
    checkOutput("offsets", offsets, packField(1));
    checkOutput("phasewords", phasewords, packField(2));
    checkOutput("commit_pending", {{(NCH*W-1){1'b0}}, commit_pending}, {{(NCH*W-1){1'b0}}, m_pend});
    checkOutput("commit_done", {{(NCH*W-1){1'b0}}, commit_done}, {{(NCH*W-1){1'b0}}, m_done});
    checkOutput("wr_err", {{(NCH*W-1){1'b0}}, wr_err}, {{(NCH*W-1){1'b0}}, m_err});
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [CW-1:0] ch,
                               input logic [1:0] f, input logic [W-1:0] d,
                               input logic c, input logic t);
    reset       = r;
    wr_en       = we;
    wr_chan     = ch;
    wr_field    = f;
    wr_data     = d;
    commit      = c;
    sample_tick = t;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 2'd0, '0, 0, 0);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, '0, 2'd0, '0, 0, 0);
    applyStimulus(1, 1, 5'd3, 2'd0, 16'hBEEF, 1, 1);
    checkOutput("reset_amps_zero", amps, '0);

    // Commit without tick, then tick
    applyStimulus(0, 1, 5'd5, 2'd0, 16'h8001, 0, 0);
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 0);
    checkOutput("tp1_pending", {511'b0, commit_pending}, 512'd1);
    checkOutput("tp1_amps_hold", amps, '0);
    idle();
    applyStimulus(0, 0, '0, 2'd0, '0, 0, 1);
    checkOutput("tp1_amp5", {496'b0, amps[95:80]}, {496'b0, 16'h8001});
    checkOutput("tp1_done", {511'b0, commit_done}, 512'd1);
    idle();
    checkOutput("tp1_done_once", {511'b0, commit_done}, 512'd0);

    // Commit and tick together
    applyStimulus(0, 1, 5'd31, 2'd2, 16'h1234, 0, 0);
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 1);
    checkOutput("tp2_phase31", {496'b0, phasewords[511:496]}, {496'b0, 16'h1234});
    checkOutput("tp2_no_pending", {511'b0, commit_pending}, 512'd0);
    idle();

    // Write on the same edge as an apply
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 0);
    applyStimulus(0, 1, 5'd0, 2'd1, 16'h00AA, 0, 1);
    checkOutput("tp3_offset0_old", {496'b0, offsets[15:0]}, 512'd0);
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 0);
    applyStimulus(0, 0, '0, 2'd0, '0, 0, 1);
    checkOutput("tp3_offset0_new", {496'b0, offsets[15:0]}, {496'b0, 16'h00AA});

    // Fill every field, one commit, one tick
    for (int ch = 0; ch < NCH; ch++)
      for (int f = 0; f < 3; f++)
        applyStimulus(0, 1, CW'(ch), 2'(f), W'(ch*3 + f + 1), 0, 0);
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 0);
    idle();
    applyStimulus(0, 0, '0, 2'd0, '0, 0, 1);
    checkOutput("tp4_amp31", {496'b0, amps[511:496]}, {496'b0, 16'd94});
    checkOutput("tp4_phase0", {496'b0, phasewords[15:0]}, {496'b0, 16'd3});

    // Reserved-field write
    applyStimulus(0, 1, 5'd7, 2'd3, 16'hFFFF, 0, 0);
    checkOutput("tp5_err", {511'b0, wr_err}, 512'd1);
    idle();
    checkOutput("tp5_err_once", {511'b0, wr_err}, 512'd0);
    applyStimulus(0, 0, '0, 2'd0, '0, 1, 1);

    // Reset while armed
    applyStimulus(0, 1, 5'd9, 2'd0, 16'h5A5A, 1, 0);
    applyStimulus(1, 0, '0, 2'd0, '0, 0, 0);
    checkOutput("tp6_amps_zero", amps, '0);
    checkOutput("tp6_pending_zero", {511'b0, commit_pending}, 512'd0);
    applyStimulus(0, 0, '0, 2'd0, '0, 0, 1);
    checkOutput("tp6_no_done", {511'b0, commit_done}, 512'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom), CW'($urandom), 2'($urandom),
                    W'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
